// File: rtl/cpu_fetch_sequencer_if.sv
// Fetch-side bus of cpu_fetch_sequencer: icache request/response, redirect
// input and the decode output stage. The sequencer uses the master modport.
//
// Handshake semantics: a transfer happens on a rising clock edge where both
// valid and ready are high. Once valid is raised it stays high with its
// payload unchanged until ready is seen. The only exception is a redirect,
// which may drop or replace a pending request or decode entry. rsp_valid has
// no ready: the icache returns responses in order and they cannot be stalled.
interface cpu_fetch_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_word;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [31:0] dec_next_pc;
    logic        fault;

    modport master (
        output req_valid, req_addr, dec_valid, dec_instr, dec_pc, dec_next_pc, fault,
        input  req_ready, rsp_valid, rsp_word, redirect_valid, redirect_pc, dec_ready
    );

    modport slave (
        input  req_valid, req_addr, dec_valid, dec_instr, dec_pc, dec_next_pc, fault,
        output req_ready, rsp_valid, rsp_word, redirect_valid, redirect_pc, dec_ready
    );
endinterface

// File: rtl/cpu_fetch_sequencer.sv
// cpu_fetch_sequencer: owns the PC, issues in-order icache requests, pairs
// returned words with their PC in a small buffer for decode, and drops the
// responses of requests made stale by a redirect.
// Optional feature macro: CPU_FETCH_MISALIGN_TRAP_EN. When defined, a
// redirect to a non word-aligned target halts fetch and raises fault until
// an aligned redirect arrives. When undefined, redirect targets are forced
// to word alignment and fault is constant 0.
module cpu_fetch_sequencer #(
    parameter logic [31:0] BOOT_ADDR       = 32'h0000_0000,
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          BUF_DEPTH       = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    cpu_fetch_sequencer_if.master        bus,
    output logic                         o_dbg_state,
    output logic [2:0]                   o_dbg_outstanding,
    output logic [2:0]                   o_dbg_drop_cnt
);

    localparam int BUF_AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int BUF_N  = 1 << BUF_AW;
    localparam int BUF_CW = $clog2(BUF_DEPTH + 1);
    localparam logic [2:0]  MAX_OUT     = 3'(MAX_OUTSTANDING);
    localparam logic [31:0] BUF_DEPTH_U = 32'(BUF_DEPTH);

    typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

    state_t r_state;
    state_t w_state_next;

    logic [31:0]       r_pc;
    logic [2:0]        r_outstanding;
    logic [2:0]        r_drop_cnt;
    logic [2:0]        w_outstanding_next;

    // In-flight PC queue: holds the PCs of requests whose responses are kept.
    logic [31:0]       r_pq [0:3];
    logic [1:0]        r_pq_wr;
    logic [1:0]        r_pq_rd;

    // Response buffer feeding decode.
    logic [31:0]       r_buf_instr [0:BUF_N-1];
    logic [31:0]       r_buf_pc    [0:BUF_N-1];
    logic [BUF_AW-1:0] r_buf_wr;
    logic [BUF_AW-1:0] r_buf_rd;
    logic [BUF_CW-1:0] r_buf_count;

    logic [31:0]       w_credit_used;
    logic              w_req_valid;
    logic              w_req_fire;
    logic              w_redirect;
    logic              w_rsp_ack;
    logic              w_rsp_drop;
    logic              w_rsp_keep;
    logic              w_dec_valid;
    logic              w_dec_pop;
    logic [31:0]       w_redirect_pc;
    logic              w_misaligned;

    assign w_redirect    = bus.redirect_valid;
    assign w_redirect_pc = {bus.redirect_pc[31:2], 2'b00};
`ifdef CPU_FETCH_MISALIGN_TRAP_EN
    assign w_misaligned  = |bus.redirect_pc[1:0];
`else
    assign w_misaligned  = 1'b0;
    wire   w_unused      = &{1'b0, bus.redirect_pc[1:0]};
`endif

    // Every icache response counts against outstanding; a response with
    // nothing in flight (e.g. left over from before reset) is ignored.
    assign w_rsp_ack  = bus.rsp_valid && (r_outstanding != 3'd0);
    assign w_rsp_drop = w_rsp_ack && !w_redirect && (r_drop_cnt != 3'd0);
    assign w_rsp_keep = w_rsp_ack && !w_redirect && (r_drop_cnt == 3'd0);

    assign w_credit_used = 32'(r_outstanding) + 32'(r_buf_count);
    assign w_req_fire    = w_req_valid && bus.req_ready;
    assign w_dec_valid   = (r_buf_count != '0);
    assign w_dec_pop     = w_dec_valid && bus.dec_ready;

    assign w_outstanding_next = r_outstanding + {2'b00, w_req_fire} - {2'b00, w_rsp_ack};

    assign bus.req_valid   = w_req_valid;
    assign bus.req_addr    = r_pc;
    assign bus.dec_valid   = w_dec_valid;
    assign bus.dec_instr   = w_dec_valid ? r_buf_instr[r_buf_rd] : 32'h0;
    assign bus.dec_pc      = w_dec_valid ? r_buf_pc[r_buf_rd] : 32'h0;
    assign bus.dec_next_pc = w_dec_valid ? (r_buf_pc[r_buf_rd] + 32'd4) : 32'h0;

    assign o_dbg_state       = r_state;
    assign o_dbg_outstanding = r_outstanding;
    assign o_dbg_drop_cnt    = r_drop_cnt;

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: only a redirect moves between RUN and HALT.
    always_comb begin
        w_state_next = ST_RUN;
`ifdef CPU_FETCH_MISALIGN_TRAP_EN
        w_state_next = r_state;
        if (w_redirect) begin
            w_state_next = w_misaligned ? ST_HALT : ST_RUN;
        end
`endif
    end

    // FSM outputs: the credit rule keeps a buffer slot free for every response.
    always_comb begin
        w_req_valid = 1'b0;
        bus.fault   = 1'b0;
        if (!reset && (r_state == ST_RUN)) begin
            w_req_valid = (r_outstanding < MAX_OUT) && (w_credit_used < BUF_DEPTH_U);
        end
`ifdef CPU_FETCH_MISALIGN_TRAP_EN
        bus.fault = (r_state == ST_HALT);
`endif
    end

    // PC, counters and queue/buffer pointers; a redirect overrides everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc          <= BOOT_ADDR;
            r_outstanding <= 3'd0;
            r_drop_cnt    <= 3'd0;
            r_pq_wr       <= 2'd0;
            r_pq_rd       <= 2'd0;
            r_buf_wr      <= '0;
            r_buf_rd      <= '0;
            r_buf_count   <= '0;
        end else begin
            r_outstanding <= w_outstanding_next;
            if (w_redirect) begin
                r_pc        <= w_redirect_pc;
                // Everything in flight after this edge belongs to the old path.
                r_drop_cnt  <= w_outstanding_next;
                r_pq_wr     <= 2'd0;
                r_pq_rd     <= 2'd0;
                r_buf_wr    <= '0;
                r_buf_rd    <= '0;
                r_buf_count <= '0;
            end else begin
                if (w_req_fire) begin
                    r_pc    <= r_pc + 32'd4;
                    r_pq_wr <= r_pq_wr + 2'd1;
                end
                if (w_rsp_drop) begin
                    r_drop_cnt <= r_drop_cnt - 3'd1;
                end
                if (w_rsp_keep) begin
                    r_pq_rd  <= r_pq_rd + 2'd1;
                    r_buf_wr <= r_buf_wr + BUF_AW'(1);
                end
                if (w_dec_pop) begin
                    r_buf_rd <= r_buf_rd + BUF_AW'(1);
                end
                r_buf_count <= r_buf_count + BUF_CW'(w_rsp_keep) - BUF_CW'(w_dec_pop);
            end
        end
    end

    // Storage writes: request PCs into the queue, kept words into the buffer.
    always_ff @(posedge clock) begin
        if (w_req_fire && !w_redirect) begin
            r_pq[r_pq_wr] <= r_pc;
        end
        if (w_rsp_keep) begin
            r_buf_instr[r_buf_wr] <= bus.rsp_word;
            r_buf_pc[r_buf_wr]    <= r_pq[r_pq_rd];
        end
    end

endmodule
